serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 24 ++
 rtl/serial_addsub.sv | 125 ++++++++++++
 tb/tb_serial_addsub.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - start/done handshake and result bus for serial_addsub
// Optional macro SERIAL_ADDSUB_ZERO_FLAG_EN adds the zero result flag.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   logic             zero;

   modport master (output start, sub, a, b, input busy, done, sum, cout, ovf, zero);
   modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf, zero);
`else
   modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
   modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial add/subtract unit, LSB-first, DIGIT bits per clock
// Optional macro SERIAL_ADDSUB_ZERO_FLAG_EN adds a registered zero-result flag.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   serial_addsub_if.slave  bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   logic             zero_q, zero_d;
`endif

   logic [DIGIT:0]   slice;
   logic [WIDTH-1:0] slice_ext;
   logic             msb_cin;

   // Ripple slice on the low digit; carry into the top bit is recovered from its sum bit
   always_comb begin
      slice     = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      slice_ext = WIDTH'(slice[DIGIT-1:0]);
      msb_cin   = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ slice[DIGIT-1];
   end

   // Next-state and datapath: accept in IDLE/DONE, shift one digit per RUN cycle
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      zero_d  = zero_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               opa_d   = bus.a;
               opb_d   = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
               zero_d  = 1'b0;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = (sum_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            carry_d = slice[DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               cout_d  = slice[DIGIT];
               ovf_d   = msb_cin ^ slice[DIGIT];
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
               zero_d  = (sum_d == '0);
`endif
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
         zero_q  <= zero_d;
`endif
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (8/1 and 16/4 instances)
// Honours SERIAL_ADDSUB_ZERO_FLAG_EN when defined.
module tb_serial_addsub;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_sum;
   bit   exp_c, exp_v;

   always #5 clk = ~clk;

   serial_addsub_if #(.WIDTH(8))  bus8 ();
   serial_addsub_if #(.WIDTH(16)) bus16 ();

   serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
   serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: modular sum with effective operand, signed overflow from operand/result signs
   task automatic model(int w, int a, int b, bit s);
      int mask, opb, full;
      mask    = (1 << w) - 1;
      opb     = s ? (~b & mask) : (b & mask);
      full    = (a & mask) + opb + int'(s);
      exp_sum = full & mask;
      exp_c   = bit'((full >> w) & 1);
      exp_v   = (((a >> (w-1)) & 1) == ((opb >> (w-1)) & 1)) &&
                (((exp_sum >> (w-1)) & 1) != ((a >> (w-1)) & 1));
   endtask

   task automatic launch8(int a, int b, bit s);
      bus8.a     = 8'(a);
      bus8.b     = 8'(b);
      bus8.sub   = s;
      bus8.start = 1'b1;
      model(8, a, b, s);
   endtask

   // Called at the negedge where start was driven; returns at the negedge of the done cycle
   task automatic wait8(string tag, int inj);
      int lat, bc;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      bus8.sub   = 1'($urandom);
      chk({tag, ".busy"}, 32'(bus8.busy), 1);
      lat = 1;
      bc  = int'(bus8.busy);
      while (!bus8.done && lat < 30) begin
         if (lat == inj) begin
            bus8.a = 8'h01; bus8.b = 8'h01; bus8.sub = 1'b0; bus8.start = 1'b1;
         end
         @(negedge clk);
         bus8.start = 1'b0;
         lat++;
         if (bus8.busy) bc++;
      end
      chk({tag, ".lat"},  32'(lat), 9);
      chk({tag, ".busyn"}, 32'(bc), 8);
      chk({tag, ".sum"},  32'(bus8.sum),  32'(exp_sum));
      chk({tag, ".cout"}, 32'(bus8.cout), 32'(exp_c));
      chk({tag, ".ovf"},  32'(bus8.ovf),  32'(exp_v));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      chk({tag, ".zero"}, 32'(bus8.zero), 32'(exp_sum == 0));
`endif
   endtask

   task automatic op16(string tag, int a, int b, bit s);
      int lat;
      @(negedge clk);
      bus16.a = 16'(a); bus16.b = 16'(b); bus16.sub = s; bus16.start = 1'b1;
      model(16, a, b, s);
      @(negedge clk);
      bus16.start = 1'b0;
      bus16.a     = 16'($urandom);
      lat = 1;
      while (!bus16.done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"},  32'(lat), 5);
      chk({tag, ".sum"},  32'(bus16.sum),  32'(exp_sum));
      chk({tag, ".cout"}, 32'(bus16.cout), 32'(exp_c));
      chk({tag, ".ovf"},  32'(bus16.ovf),  32'(exp_v));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      chk({tag, ".zero"}, 32'(bus16.zero), 32'(exp_sum == 0));
`endif
   endtask

   initial begin
      int dc, keep;
      rst = 1'b1;
      bus8.start = 1'b0;  bus8.sub = 1'b0;  bus8.a = '0;  bus8.b = '0;
      bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(bus8.busy), 0);
      chk("rst.done", 32'(bus8.done), 0);
      chk("rst.sum",  32'(bus8.sum),  0);
      chk("rst.cout", 32'(bus8.cout), 0);
      chk("rst.ovf",  32'(bus8.ovf),  0);
      chk("rst16.busy", 32'(bus16.busy), 0);
      rst = 1'b0;

      // Directed arithmetic cases
      @(negedge clk); launch8(8'h5A, 8'h3C, 1'b0); wait8("add5a3c", 0);
      @(negedge clk);
      chk("hold.done", 32'(bus8.done), 0);
      chk("hold.sum",  32'(bus8.sum),  32'h96);
      chk("hold.ovf",  32'(bus8.ovf),  1);
      @(negedge clk); launch8(8'hFF, 8'h01, 1'b0); wait8("addff01", 0);
      @(negedge clk); launch8(8'h10, 8'h20, 1'b1); wait8("sub1020", 0);
      @(negedge clk); launch8(8'h80, 8'h01, 1'b1); wait8("sub8001", 0);

      // Start while busy is ignored, then back-to-back start in the DONE cycle
      @(negedge clk); launch8(8'h33, 8'h44, 1'b0); wait8("busyign", 3);
      launch8(int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));
      wait8("b2b", 0);

      // Reset in the middle of a run
      @(negedge clk); launch8(8'hF0, 8'h0F, 1'b0);
      @(negedge clk); bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort.busy", 32'(bus8.busy), 0);
      chk("abort.done", 32'(bus8.done), 0);
      chk("abort.sum",  32'(bus8.sum),  0);
      chk("abort.cout", 32'(bus8.cout), 0);
      chk("abort.ovf",  32'(bus8.ovf),  0);
      dc = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done) dc++;
      end
      chk("abort.nodone", 32'(dc), 0);
      launch8(8'h21, 8'h12, 1'b0); wait8("postabort", 0);

      // Randomised operations against the reference
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         launch8(int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));
         wait8("rnd8", 0);
      end

      // Wide, multi-bit digit instance
      op16("add16", 16'hFFFF, 16'h0001, 1'b0);
      op16("sub16", 16'h1234, 16'h1234, 1'b1);
      for (int i = 0; i < 8; i++) begin
         keep = int'($urandom_range(65535));
         op16("rnd16", keep, int'($urandom_range(65535)), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
